// File: rtl/rr_mux_arbiter_pkg.sv
// Shared source indices, state encodings and round-robin helper for rr_mux_arbiter.
package rr_mux_arbiter_pkg;

    localparam logic [1:0] SRC0 = 2'd0;
    localparam logic [1:0] SRC1 = 2'd1;
    localparam logic [1:0] SRC2 = 2'd2;
    localparam logic [1:0] SRC3 = 2'd3;
    localparam int unsigned NUM_SRC = 4;

    // Output stage occupancy; the encoding doubles as out_valid.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // First requester found scanning ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap).
    // Scanning from the far end down lets the nearest hit overwrite the others.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int unsigned k = NUM_SRC; k > 0; k--) begin
            idx = ptr + 2'(k - 1);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_ymux.sv
// Shared 4-to-1 word multiplexer, SIZE bits wide, select c.
module yMux4to1
    import rr_mux_arbiter_pkg::*;
#(
    parameter int SIZE = 32
) (
    output logic [SIZE-1:0] z,
    input  logic [SIZE-1:0] a0,
    input  logic [SIZE-1:0] a1,
    input  logic [SIZE-1:0] a2,
    input  logic [SIZE-1:0] a3,
    input  logic [1:0]      c
);

    always_comb begin
        z = '0;
        unique case (c)
            SRC0: z = a0;
            SRC1: z = a1;
            SRC2: z = a2;
            SRC3: z = a3;
            default: z = '0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the shared yMux4to1, with a one-deep valid/ready output stage.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [SIZE-1:0]  d0,
    input  logic [SIZE-1:0]  d1,
    input  logic [SIZE-1:0]  d2,
    input  logic [SIZE-1:0]  d3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [SIZE-1:0]  out_data,
    output logic [1:0]       out_src,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_t          state, state_next;
    logic [1:0]      ptr;
    logic [1:0]      sel_q;
    logic [1:0]      winner;
    logic            accept;
    logic [SIZE-1:0] mux_out;

    assign out_valid = (state == FULL);
    assign winner    = rr_pick(req, ptr);

    // Reset gating keeps gnt quiet while reset is held, even though reset is async.
    always_comb begin
        accept = 1'b0;
        gnt    = '0;
        sel    = sel_q;
        if (!reset && (|req) && (!out_valid || out_ready)) begin
            accept = 1'b1;
            gnt    = 4'b0001 << winner;
            sel    = winner;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = FULL;
        end else if (out_valid && out_ready) begin
            state_next = EMPTY;
        end
    end

    yMux4to1 #(.SIZE(SIZE)) u_mux (
        .z  (mux_out),
        .a0 (d0),
        .a1 (d1),
        .a2 (d2),
        .a3 (d3),
        .c  (sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_src  <= SRC0;
            ptr      <= SRC0;
            sel_q    <= SRC0;
        end else if (accept) begin
            out_data <= mux_out;
            out_src  <= winner;
            ptr      <= winner + 2'd1;
            sel_q    <= winner;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: hand-computed grants, data, handshakes and reset behaviour.
module tb_rr_mux_arbiter;

    localparam int SIZE  = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [3:0]       req;
    logic [SIZE-1:0]  d0, d1, d2, d3;
    logic             out_ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic [SIZE-1:0]  out_data;
    logic [1:0]       out_src;
    logic [CNT_W-1:0] xfer_cnt;

    int nvec = 0;
    int nerr = 0;

    rr_mux_arbiter #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .xfer_cnt  (xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b1;
        d0 = 32'hA0;
        d1 = 32'hA1;
        d2 = 32'hA2;
        d3 = 32'hA3;
        #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_cnt", 64'(xfer_cnt), 64'h0);

        // Idle after reset release
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            after_edge();
            chk("idle_gnt", 64'(gnt), 64'h0);
            chk("idle_valid", 64'(out_valid), 64'h0);
            chk("idle_cnt", 64'(xfer_cnt), 64'h0);
        end

        // All four requesting: rotate 0,1,2,3,0 at full throughput
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req = 4'b1111;
            #1;
            chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (i % 4)));
            chk("rr_sel", 64'(sel), 64'(i % 4));
            after_edge();
            chk("rr_data", 64'(out_data), 64'(32'hA0 + (i % 4)));
            chk("rr_src", 64'(out_src), 64'(i % 4));
            chk("rr_valid", 64'(out_valid), 64'h1);
            chk("rr_cnt", 64'(xfer_cnt), 64'(i));
        end

        // Load A1 (ptr=1), then stall with req=0100 for three cycles
        @(negedge clk);
        req = 4'b0010;
        #1;
        chk("a1_gnt", 64'(gnt), 64'h2);
        after_edge();
        chk("a1_data", 64'(out_data), 64'hA1);
        chk("a1_cnt", 64'(xfer_cnt), 64'd5);
        @(negedge clk);
        req = 4'b0100;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_gnt", 64'(gnt), 64'h0);
            chk("bp_sel", 64'(sel), 64'h1);
            after_edge();
            chk("bp_data", 64'(out_data), 64'hA1);
            chk("bp_valid", 64'(out_valid), 64'h1);
            chk("bp_cnt", 64'(xfer_cnt), 64'd5);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_gnt", 64'(gnt), 64'h4);
        after_edge();
        chk("bp_rel_data", 64'(out_data), 64'hA2);
        chk("bp_rel_src", 64'(out_src), 64'h2);
        chk("bp_rel_cnt", 64'(xfer_cnt), 64'd6);

        // ptr=3: req=0101 scans 3 then 0, so source 0 wins
        @(negedge clk);
        req = 4'b0101;
        #1;
        chk("wrap_gnt", 64'(gnt), 64'h1);
        chk("wrap_sel", 64'(sel), 64'h0);
        after_edge();
        chk("wrap_data", 64'(out_data), 64'hA0);
        chk("wrap_cnt", 64'(xfer_cnt), 64'd7);

        // Drain, then a single request from source 1
        @(negedge clk);
        req = 4'b0000;
        #1;
        chk("drain_gnt", 64'(gnt), 64'h0);
        after_edge();
        chk("drain_valid", 64'(out_valid), 64'h0);
        chk("drain_data", 64'(out_data), 64'hA0);
        chk("drain_cnt", 64'(xfer_cnt), 64'd8);
        @(negedge clk);
        req = 4'b0010;
        #1;
        chk("single_gnt", 64'(gnt), 64'h2);
        after_edge();
        chk("single_valid", 64'(out_valid), 64'h1);
        chk("single_src", 64'(out_src), 64'h1);
        chk("single_cnt", 64'(xfer_cnt), 64'd8);
        @(negedge clk);
        req = 4'b0000;
        after_edge();
        chk("single_off", 64'(out_valid), 64'h0);
        chk("single_cnt2", 64'(xfer_cnt), 64'd9);
        after_edge();
        chk("single_stay", 64'(out_valid), 64'h0);

        // Reset while full with a pending request from source 3 (ptr=2 before reset)
        @(negedge clk);
        req = 4'b0010;
        #1;
        chk("pre_gnt", 64'(gnt), 64'h2);
        after_edge();
        @(negedge clk);
        req = 4'b1000;
        out_ready = 1'b0;
        #1;
        chk("pre_stall_gnt", 64'(gnt), 64'h0);
        chk("pre_stall_valid", 64'(out_valid), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_data", 64'(out_data), 64'h0);
        chk("mid_rst_gnt", 64'(gnt), 64'h0);
        chk("mid_rst_cnt", 64'(xfer_cnt), 64'h0);
        chk("mid_rst_sel", 64'(sel), 64'h0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_rst_gnt", 64'(gnt), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1010;
        #1;
        chk("post_rst_gnt", 64'(gnt), 64'h2);
        chk("post_rst_sel", 64'(sel), 64'h1);
        after_edge();
        chk("post_rst_data", 64'(out_data), 64'hA1);
        chk("post_rst_src", 64'(out_src), 64'h1);
        chk("post_rst_valid", 64'(out_valid), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
